att_result_drain: RTL

- Reader side of the attention result path: accepts one parallel row of LANES accumulator words from the attention engine per handshake.
- Requantizes each word from IN_W to OUT_W (arithmetic shift, round half up, saturate) and streams the words out one per cycle over valid/ready to the next stage (MLP/conv input).
- Tracks rows per frame (ROWS = HW*HW tokens); flags last lane of each row and last lane of each frame.

---
 rtl/att_result_drain_pkg.sv | 22 ++
 rtl/att_requant.sv | 42 ++++
 rtl/att_result_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/att_result_drain_pkg.sv
// Shared widths, frame geometry and drain state encoding for the attention result path.
// Imported by the requant helper and the drain top.
package att_result_drain_pkg;

   localparam int ATT_WIDTH    = 32;
   localparam int CONV16_WIDTH = 8;
   localparam int ATT2         = 8;
   localparam int HW           = 4;
   localparam int HW_ROWS      = HW * HW;
   localparam int REQ_SHIFT    = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } drain_state_t;

   // Counter width that stays legal when the count collapses to one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/att_requant.sv
// Signed requantizer: rounding arithmetic right shift (half up) followed by saturation.
// Purely combinational; shared with the MLP path.
module att_requant
   import att_result_drain_pkg::*;
#(
   parameter int IN_W  = ATT_WIDTH,
   parameter int OUT_W = CONV16_WIDTH,
   parameter int SHIFT = REQ_SHIFT
) (
   input  logic [IN_W-1:0]  i_x,
   output logic [OUT_W-1:0] o_q
);

   // One extra bit of headroom so +max plus the rounding bias cannot wrap.
   localparam logic signed [IN_W:0] SAT_MAX =
      $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [IN_W:0] SAT_MIN =
      $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

   logic signed [IN_W:0] w_ext;
   logic signed [IN_W:0] w_t;

   assign w_ext = $signed({i_x[IN_W-1], i_x});

   generate
      if (SHIFT > 0) begin : g_rnd
         localparam logic signed [IN_W:0] HALF = $signed((IN_W+1)'(1) << (SHIFT-1));
         assign w_t = (w_ext + HALF) >>> SHIFT;
      end else begin : g_pass
         assign w_t = w_ext;
      end
   endgenerate

   always_comb begin
      o_q = w_t[OUT_W-1:0];
      if (w_t > SAT_MAX)
         o_q = SAT_MAX[OUT_W-1:0];
      else if (w_t < SAT_MIN)
         o_q = SAT_MIN[OUT_W-1:0];
   end

endmodule

// File: rtl/att_result_drain.sv
// Attention result drain: latches one LANES-wide accumulator row, requantizes and
// streams it one word per cycle, tagging last lane / last frame, with zero-bubble row chaining.
module att_result_drain
   import att_result_drain_pkg::*;
#(
   parameter int IN_W  = ATT_WIDTH,
   parameter int OUT_W = CONV16_WIDTH,
   parameter int LANES = ATT2,
   parameter int ROWS  = HW_ROWS,
   parameter int SHIFT = REQ_SHIFT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*IN_W-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_last_lane,
   output logic                     out_last_frame,
   output logic [$clog2(ROWS)-1:0]  row_idx
);

   localparam int LW = cnt_w(LANES);
   localparam int RW = $clog2(ROWS);
   localparam logic [LW-1:0] LANE_LAST = LW'(LANES-1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS-1);

   drain_state_t                 r_state;
   logic [LW-1:0]                r_lane;
   logic [RW-1:0]                r_row;
   logic [LANES-1:0][IN_W-1:0]   r_hold;

   logic                         w_shift;
   logic                         w_lane_last;
   logic                         w_beat;
   logic                         w_row_done;
   logic                         w_load;
   logic [IN_W-1:0]              w_word;
   logic [OUT_W-1:0]             w_q;

   assign w_shift     = (r_state == ST_SHIFT);
   assign w_lane_last = (r_lane == LANE_LAST);
   assign w_beat      = w_shift && out_ready;
   assign w_row_done  = w_beat && w_lane_last;

   // Ready reaches back combinationally through out_ready so the next row can
   // be taken on the same edge the final lane drains.
   assign in_ready = !w_shift || w_row_done;
   assign w_load   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_lane  <= '0;
         r_row   <= '0;
         r_hold  <= '0;
      end else begin
         if (w_load)
            r_hold <= in_data;
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_lane  <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_beat) begin
                  if (w_lane_last) begin
                     r_lane <= '0;
                     r_row  <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                     if (!in_valid)
                        r_state <= ST_IDLE;
                  end else begin
                     r_lane <= r_lane + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_word = r_hold[r_lane];

   att_requant #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .i_x (w_word),
      .o_q (w_q)
   );

   // Outputs are functions of held state only, so they cannot move while stalled.
   assign out_valid      = w_shift;
   assign out_data       = w_shift ? w_q : '0;
   assign out_last_lane  = w_shift && w_lane_last;
   assign out_last_frame = out_last_lane && (r_row == ROW_LAST);
   assign row_idx        = r_row;

   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(row_idx)
                                     && $stable(out_last_lane) && $stable(out_last_frame)));

   a_frame_implies_lane: assert property (@(posedge clk) disable iff (!rst_n)
      out_last_frame |-> out_last_lane);

endmodule
